fnd_scan_controller: RTL and testbench

//  Parametrised multiplexed 7-segment (FND) scan driver for N common-anode digits.
//  - Takes packed BCD digits plus per-digit decimal points and scans one digit per scan tick.
//  - Adds three things to the fixed 4-digit scanner: frame-synchronous input latching (no tearing),
//    a ghost-suppression blank interval between digits, and a frame_done strobe.
//  - Sits between the time/counter datapath (stopwatch, watch) and the board FND pins.

---
 rtl/fnd_pkg.sv | 24 ++
 rtl/fnd_scan_controller_if.sv | 31 +++
 rtl/fnd_seg_decoder.sv | 32 +++
 rtl/fnd_scan_controller.sv | 151 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
// Shared constants for the multiplexed 7-segment (FND) scan driver.
// Segment codes are active-low in the order g..a (bit 6 = g, bit 0 = a).
// The decimal point is not part of these codes. The top module adds it as bit 7.
// ---------------------------------------------------------------------------
package fnd_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DARK = 7'h7F;

  // All segments and the decimal point are off.
  localparam logic [7:0] FND_ALL_OFF = 8'hFF;

endpackage

// File: rtl/fnd_scan_controller_if.sv
// ---------------------------------------------------------------------------
// fnd_scan_controller_if
// Bundle between the display datapath and the FND scan driver.
//   bcd_in     : packed BCD, nibble k = digit k, digit 0 = rightmost
//   dp_in      : decimal point per digit, 1 = lit
//   fnd_data   : segment pins, active-low, bit7 = dp, bits6:0 = g..a
//   fnd_com    : digit commons, active-low, at most one low
//   frame_done : 1-cycle strobe when a new frame of inputs is latched
// The master modport is the datapath side. The slave modport is the scan controller.
// ---------------------------------------------------------------------------
interface fnd_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [7:0]              fnd_data;
  logic [NUM_DIGITS-1:0]   fnd_com;
  logic                    frame_done;

  modport master (
    output bcd_in, dp_in,
    input  fnd_data, fnd_com, frame_done
  );

  modport slave (
    input  bcd_in, dp_in,
    output fnd_data, fnd_com, frame_done
  );

endinterface

// File: rtl/fnd_seg_decoder.sv
// ---------------------------------------------------------------------------
// fnd_seg_decoder
// Combinational lookup from a 4-bit BCD nibble to an active-low 7-segment code.
//   nibble_i : BCD digit, values 10..15 are not BCD
//   seg_o    : segments g..a, active-low. Non-BCD values are dark.
// ---------------------------------------------------------------------------
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Non-BCD nibbles show nothing. They are not shown as hex letters.
  always_comb begin
    seg_o = SEG_DARK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DARK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// ---------------------------------------------------------------------------
// fnd_scan_controller
// Multiplexed scan driver for NUM_DIGITS common-anode 7-segment digits.
// It shows one digit per scan tick. Inputs are latched once per frame, so a
// frame never mixes old and new values. After each digit advance, all commons
// stay off for BLANK_CYCLES clocks to suppress ghosting.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fnd_scan_controller_if.slave (bcd_in, dp_in -> fnd_data, fnd_com, frame_done)
// Optional feature macro: FND_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (above digit 0) are shown dark.
// ---------------------------------------------------------------------------
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int SCAN_FREQ    = 1_000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 0
) (
  input logic                  clk,
  input logic                  reset,
  fnd_scan_controller_if.slave bus
);

  localparam int DIV     = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLANK_W-1:0]      blank_q, blank_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   fnd_com_q;
  logic [7:0]              fnd_data_q;

  logic       tick;
  logic [3:0] nibble;
  logic       dp_sel;
  logic [6:0] seg_decoded;
  logic [6:0] seg_shown;

  // This block computes the next state of the prescaler, digit index, blank
  // counter and shadow registers. The shadow copy is taken only on the tick
  // that wraps the index to 0, so a frame never shows a mix of old and new inputs.
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    blank_d      = blank_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    frame_done_d = 1'b0;
    if (tick) begin
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      blank_d = BLANK_LOAD;
      if (idx_d == '0) begin
        shadow_bcd_d = bus.bcd_in;
        shadow_dp_d  = bus.dp_in;
        frame_done_d = 1'b1;
      end
    end else if (blank_q != '0) begin
      blank_d = blank_q - 1'b1;
    end
  end

  // This is the state register. After reset the shadow holds 4'hF nibbles,
  // which decode dark, so the display stays blank until the first frame is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blank_q      <= '0;
      shadow_bcd_q <= '1;
      shadow_dp_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blank_q      <= blank_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  // This selects the nibble and decimal point of the digit currently being scanned.
  always_comb begin
    nibble = shadow_bcd_q[idx_q*4 +: 4];
    dp_sel = shadow_dp_q[idx_q];
  end

  fnd_seg_decoder u_seg_decoder (
    .nibble_i (nibble),
    .seg_o    (seg_decoded)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_seen;

  // This walks down from the most significant digit. Each zero digit is masked
  // until the first nonzero digit is found. Digit 0 is never masked, so a value
  // of zero still shows a single "0".
  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (shadow_bcd_q[4*k +: 4] != 4'd0) begin
        lz_seen = 1'b1;
      end
      lz_mask[k] = ~lz_seen;
    end
  end

  always_comb begin
    seg_shown = lz_mask[idx_q] ? SEG_DARK : seg_decoded;
  end
`else
  always_comb begin
    seg_shown = seg_decoded;
  end
`endif

  // These are the registered pin drivers. They lag the index and blank counter
  // by one clock, so the blank window appears on the pins for exactly BLANK_CYCLES clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com_q  <= '1;
      fnd_data_q <= FND_ALL_OFF;
    end else if (blank_q != '0) begin
      fnd_com_q  <= '1;
      fnd_data_q <= FND_ALL_OFF;
    end else begin
      fnd_com_q  <= ~(NUM_DIGITS'(1) << idx_q);
      fnd_data_q <= {~dp_sel, seg_shown};
    end
  end

  assign bus.fnd_com    = fnd_com_q;
  assign bus.fnd_data   = fnd_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_controller
// Directed bench for fnd_scan_controller with DIV=10, NUM_DIGITS=4 and
// BLANK_CYCLES=2. Edge numbers count rising clock edges after reset release.
// A frame latched at edge 40k shows digit d on edges 40k+10d+3 .. 40k+10d+10.
// Expected values depend on whether FND_LEADING_ZERO_BLANK_EN is defined.
// ---------------------------------------------------------------------------
module tb_fnd_scan_controller;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   edgeNo;

  fnd_scan_controller_if #(.NUM_DIGITS(4)) bus ();

  fnd_scan_controller #(
    .CLK_FREQ     (1000),
    .SCAN_FREQ    (100),
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This advances one rising edge and samples 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    edgeNo++;
  endtask

  task automatic goTo(input int target);
    while (edgeNo < target) cyc();
  endtask

  task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dp);
    bus.bcd_in = bcd;
    bus.dp_in  = dp;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expCom, input logic [7:0] expData);
    checks++;
    assert (bus.fnd_com === expCom)
    else begin
      failures++;
      $error("FAIL %s com observed=%b expected=%b (edge %0d)", tag, bus.fnd_com, expCom, edgeNo);
    end
    checks++;
    assert (bus.fnd_data === expData)
    else begin
      failures++;
      $error("FAIL %s data observed=%h expected=%h (edge %0d)", tag, bus.fnd_data, expData, edgeNo);
    end
  endtask

  task automatic checkFrameDone(input string tag, input logic expFd);
    checks++;
    assert (bus.frame_done === expFd)
    else begin
      failures++;
      $error("FAIL %s frame_done observed=%b expected=%b (edge %0d)", tag, bus.frame_done, expFd, edgeNo);
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int fdCount;
    int offCount;
    logic [7:0] lzD1;
    logic [7:0] lzD2;
    logic [7:0] lzD3;
    logic [7:0] lz0A09D3;
    checks   = 0;
    failures = 0;
    edgeNo   = 0;
    reset    = 1'b1;
    applyStimulus(16'h1234, 4'b0000);

    // The display must be fully off while reset is held.
    cyc();
    cyc();
    checkOutput("inReset", 4'b1111, 8'hFF);
    checkFrameDone("inResetFd", 1'b0);
    reset  = 1'b0;
    edgeNo = 0;

    // In the first frame after reset the shadow is dark while digits are scanned.
    goTo(1);
    checkOutput("darkD0", 4'b1110, 8'hFF);
    goTo(15);
    checkOutput("darkD1", 4'b1101, 8'hFF);
    goTo(39);
    checkFrameDone("fdBefore", 1'b0);
    checkOutput("darkD3", 4'b0111, 8'hFF);
    goTo(40);
    checkFrameDone("fdFirst", 1'b1);

    // Frame 1 shows 1234. This also checks the blank windows and that frame_done pulses once per frame.
    fdCount  = 0;
    offCount = 0;
    for (int e = 41; e <= 80; e++) begin
      cyc();
      if (bus.frame_done === 1'b1) fdCount++;
      if (bus.fnd_com === 4'b1111 && bus.fnd_data === 8'hFF) offCount++;
      case (e)
        41, 42:  checkOutput("blank0", 4'b1111, 8'hFF);
        43:      checkOutput("d0first", 4'b1110, 8'h99);
        45:      checkOutput("d0", 4'b1110, 8'h99);
        51, 52:  checkOutput("blank1", 4'b1111, 8'hFF);
        53:      checkOutput("d1", 4'b1101, 8'hB0);
        65:      checkOutput("d2", 4'b1011, 8'hA4);
        75:      checkOutput("d3", 4'b0111, 8'hF9);
        79:      checkFrameDone("fdLow", 1'b0);
        default: ;
      endcase
    end
    checkCount("fdPerFrame", fdCount, 1);
    checkCount("offCycles", offCount, 8);

    // A change in the middle of a frame must not appear until the next latch.
    goTo(85);
    checkOutput("f2d0", 4'b1110, 8'h99);
    goTo(95);
    applyStimulus(16'h5678, 4'b0000);
    goTo(105);
    checkOutput("noTearD2", 4'b1011, 8'hA4);
    goTo(115);
    checkOutput("noTearD3", 4'b0111, 8'hF9);
    goTo(120);
    checkFrameDone("fd3", 1'b1);
    goTo(125);
    checkOutput("newD0", 4'b1110, 8'h80);
    goTo(135);
    checkOutput("newD1", 4'b1101, 8'hF8);

    // This checks non-BCD nibbles and decimal points: 0A09 with the dp on digit 1.
`ifdef FND_LEADING_ZERO_BLANK_EN
    lz0A09D3 = 8'hFF;
`else
    lz0A09D3 = 8'hC0;
`endif
    applyStimulus(16'h0A09, 4'b0010);
    goTo(165);
    checkOutput("hexD0", 4'b1110, 8'h90);
    goTo(175);
    checkOutput("dpD1", 4'b1101, 8'h40);
    goTo(185);
    checkOutput("hexD2dark", 4'b1011, 8'hFF);
    goTo(195);
    checkOutput("hexD3", 4'b0111, lz0A09D3);
    applyStimulus(16'h0A09, 4'b0100);
    goTo(215);
    checkOutput("dpOffD1", 4'b1101, 8'hC0);
    goTo(225);
    checkOutput("darkDpD2", 4'b1011, 8'h7F);

    // Leading zero patterns give different results depending on the build option.
`ifdef FND_LEADING_ZERO_BLANK_EN
    lzD2 = 8'hFF;
    lzD3 = 8'hFF;
    lzD1 = 8'hFF;
`else
    lzD2 = 8'hC0;
    lzD3 = 8'hC0;
    lzD1 = 8'hC0;
`endif
    applyStimulus(16'h0050, 4'b0000);
    goTo(245);
    checkOutput("lz0050d0", 4'b1110, 8'hC0);
    goTo(255);
    checkOutput("lz0050d1", 4'b1101, 8'h92);
    goTo(265);
    checkOutput("lz0050d2", 4'b1011, lzD2);
    goTo(275);
    checkOutput("lz0050d3", 4'b0111, lzD3);
    applyStimulus(16'h0000, 4'b0000);
    goTo(285);
    checkOutput("lz0000d0", 4'b1110, 8'hC0);
    goTo(295);
    checkOutput("lz0000d1", 4'b1101, lzD1);
    goTo(315);
    checkOutput("lz0000d3", 4'b0111, lzD3);
    applyStimulus(16'h1005, 4'b0000);
    goTo(325);
    checkOutput("lz1005d0", 4'b1110, 8'h92);
    goTo(335);
    checkOutput("lz1005d1", 4'b1101, 8'hC0);
    goTo(345);
    checkOutput("lz1005d2", 4'b1011, 8'hC0);
    goTo(355);
    checkOutput("lz1005d3", 4'b0111, 8'hF9);

    // Reset while idx=2 and blank_cnt=1 (tick at edge 380). The outputs must clear
    // at once, then a new dark frame must start from digit 0.
    goTo(381);
    checkOutput("preRstBlank", 4'b1111, 8'hFF);
    reset = 1'b1;
    #1;
    checkOutput("asyncRst", 4'b1111, 8'hFF);
    checkFrameDone("asyncRstFd", 1'b0);
    cyc();
    cyc();
    checkOutput("heldRst", 4'b1111, 8'hFF);
    reset  = 1'b0;
    edgeNo = 0;
    goTo(1);
    checkOutput("rstDarkD0", 4'b1110, 8'hFF);
    goTo(15);
    checkOutput("rstDarkD1", 4'b1101, 8'hFF);
    goTo(39);
    checkFrameDone("rstFdBefore", 1'b0);
    goTo(40);
    checkFrameDone("rstFd", 1'b1);
    goTo(45);
    checkOutput("rstD0", 4'b1110, 8'h92);
    goTo(55);
    checkOutput("rstD1", 4'b1101, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
